ssb_re_extractor: RTL

Extracts a parametrised window of resource elements (default: the 127 SSS subcarriers) from the per-subcarrier FFT_demod output stream and demaps them to hard or soft bits. Feeds them to a downstream detector (SSS_detector or later PBCH decoder) over an AXI-stream with backpressure. Sequences the N_id_2 handoff, per-symbol capture, detector-completion wait and timeout. Sits between FFT_demod and the detector; replaces the ad-hoc SSS capture FSM in the receiver top.

---
 rtl/ssb_re_extractor_pkg.sv | 29 ++
 rtl/ssb_re_extractor_if.sv | 20 ++
 rtl/ssb_re_extractor_re_fifo.sv | 71 +++++++
 rtl/ssb_re_extractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ssb_re_extractor_pkg.sv
// ----------------------------------------------------------------------------
// ssb_pkg
// Shared types and constants for the SSB resource-element extractor.
//   state_t          : capture sequencer states
//   SSS_START/SSS_LEN: default RE window (the 127 SSS subcarriers)
//   N_ID_2_W         : width of the PSS index
//   FFT_OUT_DW_DEF   : default FFT sample width
//   cnt_width()      : counter/pointer width helper, never returns 0
// ----------------------------------------------------------------------------
package ssb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SYM = 2'd1,
      ST_CAPTURE  = 2'd2,
      ST_WAIT_DET = 2'd3
   } state_t;

   localparam int SSS_LEN        = 127;
   localparam int SSS_START      = 64;
   localparam int N_ID_2_W       = 2;
   localparam int FFT_OUT_DW_DEF = 32;

   // Bits needed to hold values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ssb_re_extractor_if.sv
// ----------------------------------------------------------------------------
// ssb_re_extractor_if
// AXI-stream style bus carrying demapped bits to the detector.
//   tdata  : demapped bit(s), DW wide
//   tvalid : data valid
//   tready : sink ready
//   tlast  : last bit of a captured RE window
// master = extractor side, slave = detector side.
// ----------------------------------------------------------------------------
interface ssb_re_extractor_if #(
   parameter int DW = 1
) ();
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic          tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ssb_re_extractor_re_fifo.sv
// ----------------------------------------------------------------------------
// re_fifo
// Small first-word-fall-through FIFO for demapped bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or full with pop)
//   pop        : consume the head entry (ignored when empty)
//   flush      : empty the FIFO; a push in the same cycle lands in the
//                freshly emptied FIFO
//   pop_data   : head entry, forced to 0 while empty
//   full/empty : occupancy flags
// ----------------------------------------------------------------------------
module re_fifo
   import ssb_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;
   logic [AW-1:0]    wr_addr;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty && !flush;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (flush || !full || do_pop);
   assign wr_addr = flush ? '0 : wr_ptr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= AW'(do_push);
         rd_ptr_reg <= '0;
         count_reg  <= (AW+1)'(do_push);
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_addr] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/ssb_re_extractor.sv
// ----------------------------------------------------------------------------
// ssb_re_extractor
// Captures a window of subcarriers (default: the 127 SSS REs) from the FFT
// demod stream, demaps each to hard/soft bits and streams them out with
// backpressure. Also sequences N_id_2 handoff, detector wait and timeout.
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   N_id_2_i/_valid_i      : PSS index and its detection pulse
//   sym_start_i            : marks subcarrier 0 of the target symbol
//   s_axis_in_tdata/tvalid : FFT samples (real = low half, imag = high half)
//   m_axis_N_id_2_*        : latched PSS index, one-cycle valid pulse
//   m_axis_out             : demapped bits (master side of the stream bus)
//   det_done_i             : detector finished
//   busy_o                 : sequencer not idle
//   abort_o, timeout_o     : one-cycle event pulses
//   overflow_o             : sticky, a captured bit was dropped
// ----------------------------------------------------------------------------
module ssb_re_extractor
   import ssb_pkg::*;
#(
   parameter int FFT_OUT_DW = FFT_OUT_DW_DEF,
   parameter int NFFT       = 256,
   parameter int RE_START   = SSS_START,
   parameter int RE_LEN     = SSS_LEN,
   parameter int SOFT_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 4096,
   parameter int CONTINUOUS = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic [N_ID_2_W-1:0]   N_id_2_i,
   input  logic                  N_id_2_valid_i,
   input  logic                  sym_start_i,
   input  logic [FFT_OUT_DW-1:0] s_axis_in_tdata,
   input  logic                  s_axis_in_tvalid,
   output logic [N_ID_2_W-1:0]   m_axis_N_id_2_tdata,
   output logic                  m_axis_N_id_2_tvalid,
   ssb_re_extractor_if.master    m_axis_out,
   input  logic                  det_done_i,
   output logic                  busy_o,
   output logic                  abort_o,
   output logic                  timeout_o,
   output logic                  overflow_o
);
   localparam int CW   = $clog2(NFFT + 1);
   localparam int TW   = cnt_width(TIMEOUT);
   localparam int HALF = FFT_OUT_DW / 2;

   localparam logic [CW-1:0] WIN_LO   = CW'(RE_START);
   localparam logic [CW-1:0] WIN_LAST = CW'(RE_START + RE_LEN - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam state_t        DONE_ST  = (CONTINUOUS != 0) ? ST_WAIT_SYM : ST_IDLE;

   state_t              state_reg, state_next;
   logic [CW-1:0]       sc_cnt_reg, sc_cnt_next;
   logic [TW-1:0]       to_cnt_reg, to_cnt_next;
   logic [N_ID_2_W-1:0] nid_reg, nid_next;
   logic                nid_pulse_reg, nid_pulse_next;
   logic                abort_reg, abort_next;
   logic                timeout_reg, timeout_next;
   logic                overflow_reg, overflow_next;

   logic                 restart;
   logic                 take_sample;
   logic [CW-1:0]        idx;
   logic                 in_win;
   logic                 is_last;
   logic                 fifo_push, fifo_flush, fifo_pop;
   logic                 fifo_full, fifo_empty;
   logic                 push_last;
   logic                 ovf_clear;
   logic [SOFT_BITS-1:0] demap_bits;
   logic [SOFT_BITS:0]   fifo_dout;

   // Only the top SOFT_BITS of the real part are used.
   wire unused_tdata = ^s_axis_in_tdata;

   assign restart     = sym_start_i && s_axis_in_tvalid;
   // A sample enters the index counter either as a new symbol's subcarrier 0
   // or as the next subcarrier of the symbol being captured.
   assign take_sample = ((state_reg == ST_WAIT_SYM) && restart) ||
                        ((state_reg == ST_CAPTURE) && s_axis_in_tvalid);
   assign idx         = ((state_reg == ST_CAPTURE) && !restart) ? sc_cnt_reg : '0;
   assign in_win      = (idx >= WIN_LO) && (idx <= WIN_LAST);
   assign is_last     = (idx == WIN_LAST);
   // For SOFT_BITS==1 this is just the sign bit of the real part.
   assign demap_bits  = s_axis_in_tdata[HALF-1 -: SOFT_BITS];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg     <= ST_IDLE;
         sc_cnt_reg    <= '0;
         to_cnt_reg    <= '0;
         nid_reg       <= '0;
         nid_pulse_reg <= 1'b0;
         abort_reg     <= 1'b0;
         timeout_reg   <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sc_cnt_reg    <= sc_cnt_next;
         to_cnt_reg    <= to_cnt_next;
         nid_reg       <= nid_next;
         nid_pulse_reg <= nid_pulse_next;
         abort_reg     <= abort_next;
         timeout_reg   <= timeout_next;
         overflow_reg  <= overflow_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      sc_cnt_next    = sc_cnt_reg;
      to_cnt_next    = to_cnt_reg;
      nid_next       = nid_reg;
      nid_pulse_next = 1'b0;
      abort_next     = 1'b0;
      timeout_next   = 1'b0;
      fifo_push      = 1'b0;
      fifo_flush     = 1'b0;
      push_last      = 1'b0;
      ovf_clear      = 1'b0;

      if (N_id_2_valid_i) begin
         // A new PSS detection overrides whatever else happens this cycle.
         nid_next       = N_id_2_i;
         nid_pulse_next = 1'b1;
         fifo_flush     = 1'b1;
         ovf_clear      = 1'b1;
         sc_cnt_next    = '0;
         abort_next     = (state_reg == ST_CAPTURE);
         state_next     = ST_WAIT_SYM;
      end else begin
         case (state_reg)
            ST_WAIT_SYM, ST_CAPTURE: begin
               if ((state_reg == ST_CAPTURE) && restart) begin
                  // Symbol boundary before the window completed: discard it.
                  fifo_flush = 1'b1;
                  abort_next = 1'b1;
               end
               if (take_sample) begin
                  sc_cnt_next = idx + 1'b1;
                  state_next  = ST_CAPTURE;
                  if (in_win) begin
                     fifo_push = 1'b1;
                     if (is_last) begin
                        push_last   = 1'b1;
                        to_cnt_next = '0;
                        state_next  = ST_WAIT_DET;
                     end
                  end
               end
            end
            ST_WAIT_DET: begin
               // det_done_i takes precedence over an expiring timer.
               if (det_done_i) begin
                  state_next = DONE_ST;
               end else if (to_cnt_reg == TO_LAST) begin
                  timeout_next = 1'b1;
                  state_next   = DONE_ST;
               end else begin
                  to_cnt_next = to_cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end

      overflow_next = ovf_clear ? 1'b0
                    : (overflow_reg || (fifo_push && fifo_full && !fifo_pop && !fifo_flush));
   end

   re_fifo #(
      .WIDTH (SOFT_BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst_n     (reset_ni),
      .push      (fifo_push),
      .push_data ({push_last, demap_bits}),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign fifo_pop          = m_axis_out.tvalid && m_axis_out.tready;
   assign m_axis_out.tvalid = !fifo_empty;
   assign m_axis_out.tdata  = fifo_dout[SOFT_BITS-1:0];
   assign m_axis_out.tlast  = fifo_dout[SOFT_BITS];

   assign m_axis_N_id_2_tdata  = nid_reg;
   assign m_axis_N_id_2_tvalid = nid_pulse_reg;
   assign busy_o               = (state_reg != ST_IDLE);
   assign abort_o              = abort_reg;
   assign timeout_o            = timeout_reg;
   assign overflow_o           = overflow_reg;

endmodule
